// File: rtl/ieee_to_flopoco_encoder_pkg.sv
// ieee_to_flopoco_encoder_pkg: shared FloPoCo format constants and exception codes
package ieee_to_flopoco_encoder_pkg;
  localparam int FP_WE = 11;
  localparam int FP_WF = 20;
  localparam int FP_IN_WF = 52;
  localparam int FP_BIAS = 1023;
  localparam int FP_W = FP_WE + FP_WF + 3;
  localparam int EXC_HI = FP_W - 1;
  localparam int EXC_LO = FP_W - 2;
  localparam int SIGN_BIT = FP_WE + FP_WF;
  localparam int EXP_HI = FP_WE + FP_WF - 1;
  localparam int EXP_LO = FP_WF;
  localparam int FRAC_HI = FP_WF - 1;
  localparam int FRAC_LO = 0;
  typedef enum logic [1:0] {
    EXC_ZERO = 2'b00,
    EXC_NORM = 2'b01,
    EXC_INF  = 2'b10,
    EXC_NAN  = 2'b11
  } exc_e;
endpackage

// File: rtl/ieee_to_flopoco_encoder_rne_round.sv
// ieee_to_flopoco_encoder_rne_round: round-to-nearest-even of {exp,frac} with overflow detect
module ieee_to_flopoco_encoder_rne_round #(
  parameter int WE = 11,
  parameter int WF = 20
) (
  input  logic [WE+WF-1:0] ef,
  input  logic             guard,
  input  logic             sticky,
  output logic [WE+WF-1:0] rounded,
  output logic             overflow
);
  logic round_up;
  assign round_up = guard && (sticky || ef[0]);
  // a fraction carry ripples into the exponent through the single wide add
  assign rounded = ef + {{(WE+WF-1){1'b0}}, round_up};
  assign overflow = &rounded[WF +: WE];
endmodule

// File: rtl/ieee_to_flopoco_encoder.sv
// ieee_to_flopoco_encoder: 2-stage binary64 to FloPoCo converter with RNE and event counters
module ieee_to_flopoco_encoder
  import ieee_to_flopoco_encoder_pkg::*;
#(
  parameter int WE = FP_WE,
  parameter int WF = FP_WF,
  parameter int IN_WF = FP_IN_WF,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WE+IN_WF:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WE+WF+2:0]   out_data,
  output logic               out_inexact,
  input  logic               cnt_clear,
  output logic [CNT_W-1:0]   flush_cnt,
  output logic [CNT_W-1:0]   inexact_cnt
);
  localparam int GW = IN_WF - WF;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic s1_valid, s2_valid, s1_adv, s2_adv, fire;
  logic s1_sign, s1_guard, s1_sticky, s1_flush, s2_flush;
  logic [WE-1:0] s1_exp, in_exp;
  logic [WF-1:0] s1_frac;
  logic [IN_WF-1:0] in_frac;
  logic in_zero_exp, in_frac_nz, norm, rnd_ovf, s2_inexact_n;
  exc_e s1_exc, in_exc, s2_exc_n;
  logic [WE+WF-1:0] rnd_ef, s2_ef_n;
  assign in_exp = in_data[IN_WF +: WE];
  assign in_frac = in_data[IN_WF-1:0];
  assign in_zero_exp = in_exp == '0;
  assign in_frac_nz = |in_frac;
  assign in_exc = in_zero_exp ? EXC_ZERO : (&in_exp) ? (in_frac_nz ? EXC_NAN : EXC_INF) : EXC_NORM;
  assign s2_adv = !s2_valid || out_ready;
  assign s1_adv = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign out_valid = s2_valid;
  assign fire = s2_valid && out_ready;
  ieee_to_flopoco_encoder_rne_round #(.WE(WE), .WF(WF)) u_rne_round (
    .ef({s1_exp, s1_frac}),
    .guard(s1_guard),
    .sticky(s1_sticky),
    .rounded(rnd_ef),
    .overflow(rnd_ovf)
  );
  assign norm = s1_exc == EXC_NORM;
  assign s2_exc_n = (norm && rnd_ovf) ? EXC_INF : s1_exc;
  assign s2_ef_n = (norm && !rnd_ovf) ? rnd_ef : '0;
  assign s2_inexact_n = s1_flush || (norm && (s1_guard || s1_sticky));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign <= 1'b0;
      s1_exp <= '0;
      s1_frac <= '0;
      s1_guard <= 1'b0;
      s1_sticky <= 1'b0;
      s1_flush <= 1'b0;
      s1_exc <= EXC_ZERO;
      s2_valid <= 1'b0;
      s2_flush <= 1'b0;
      out_data <= '0;
      out_inexact <= 1'b0;
      flush_cnt <= '0;
      inexact_cnt <= '0;
    end else begin
      if (s1_adv) s1_valid <= in_valid;
      if (s1_adv && in_valid) begin
        s1_sign <= in_data[WE+IN_WF];
        s1_exp <= in_exp;
        s1_frac <= in_frac[IN_WF-1 -: WF];
        s1_guard <= in_frac[GW-1];
        s1_sticky <= |in_frac[GW-2:0];
        s1_flush <= in_zero_exp && in_frac_nz;
        s1_exc <= in_exc;
      end
      if (s2_adv) s2_valid <= s1_valid;
      if (s2_adv && s1_valid) begin
        out_data <= {s2_exc_n, s1_sign, s2_ef_n};
        out_inexact <= s2_inexact_n;
        s2_flush <= s1_flush;
      end
      flush_cnt <= cnt_clear ? '0 : (fire && s2_flush && flush_cnt != CNT_MAX) ? flush_cnt + 1'b1 : flush_cnt;
      inexact_cnt <= cnt_clear ? '0 : (fire && out_inexact && inexact_cnt != CNT_MAX) ? inexact_cnt + 1'b1 : inexact_cnt;
    end
  end
endmodule
